// File: rtl/bf_loader.sv
// bf_loader: streams Brainfuck source text into encoded code memory bytes.
//
// Merges runs of +/- and </> into single signed-delta bytes, encodes the
// single-byte commands, and emits '[' as a two-byte forward jump whose
// offset is back-patched when the matching ']' is seen.
//
// Ports
//   clk, resetq             clock, asynchronous active-low reset
//   in_valid/in_ready       source character handshake (transfer at posedge)
//   in_data, in_last        ASCII character, final-character marker
//   code_wr/waddr/wdata     registered code memory write port
//   done, error             sticky completion / rejection flags
//   prog_len                next free code address (bytes emitted so far)
//
// state        | meaning
// -------------+---------------------------------------------------------
// ACCEPT       | taking characters; first byte of any output written here
// FLUSH        | bubble after a run split; writes the new run if it was last
// EMIT         | write the held command byte after a pending run flush
// BR_LO        | write zero low byte of '[' and push its address
// CL_PATCH_HI  | patch high byte of the matching '[' with the offset
// CL_PATCH_LO  | patch low byte of the matching '[' with the offset
// DONE         | program fully emitted
// ERROR        | program rejected, no further writes
module bf_loader #(
  parameter int CADDR_WIDTH = 13,
  parameter int SDEPTH      = 5
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   code_wr,
  output logic [CADDR_WIDTH-1:0] code_waddr,
  output logic [7:0]             code_wdata,
  output logic                   done,
  output logic                   error,
  output logic [CADDR_WIDTH-1:0] prog_len
);

  typedef enum logic [2:0] {
    ACCEPT, FLUSH, EMIT, BR_LO, CL_PATCH_HI, CL_PATCH_LO, DONE, ERROR
  } state_t;

  typedef enum logic [1:0] {K_DOT, K_COMMA, K_OPEN, K_CLOSE} kind_t;

  localparam int SENTRIES = 2**SDEPTH;
  localparam logic [SDEPTH:0] DEPTH_FULL = {1'b1, {SDEPTH{1'b0}}};

  state_t state, state_nxt;

  // Character decode
  logic  is_pm, is_lr, is_run, is_cmd, c_up;
  kind_t c_kind;

  // Pending run: run_cls=1 for +/-, 0 for </>; run_d is a 6-bit two's complement delta
  logic       run_cls, run_cls_n;
  logic [5:0] run_d, run_d_n, step, run_sum;
  logic       pend, sat;
  logic [7:0] run_byte;

  // Command held across the flush/emit sequence
  kind_t cmd_q;
  logic  last_q, hold_ld;

  // Bracket stack of second-byte addresses of open '['
  logic [CADDR_WIDTH-1:0] stk [SENTRIES];
  logic [SDEPTH:0]        depth;
  logic [SDEPTH-1:0]      top_idx;
  logic [CADDR_WIDTH-1:0] top;
  logic                   stk_empty, stk_full, push, pop;

  // Patch target and offset for the ']' in progress
  logic [CADDR_WIDTH-1:0] s_q, off_q;
  logic [12:0]            off13;

  logic                   xfer, addr_full, bad_cmd, last_unbal;
  logic                   wr_en, len_inc;
  logic [CADDR_WIDTH-1:0] wr_addr;
  logic [7:0]             wr_byte;

  function automatic logic [7:0] cmd_byte(input kind_t k);
    case (k)
      K_DOT:   cmd_byte = 8'hE0;
      K_COMMA: cmd_byte = 8'hC0;
      K_OPEN:  cmd_byte = 8'hA0;
      default: cmd_byte = 8'h80;
    endcase
  endfunction

  function automatic state_t after_cmd(input kind_t k, input logic last);
    case (k)
      K_OPEN:  after_cmd = BR_LO;
      K_CLOSE: after_cmd = CL_PATCH_HI;
      default: after_cmd = last ? DONE : ACCEPT;
    endcase
  endfunction

  always_comb begin
    is_pm  = 1'b0;
    is_lr  = 1'b0;
    c_up   = 1'b0;
    is_cmd = 1'b0;
    c_kind = K_DOT;
    case (in_data)
      8'h2B: begin is_pm = 1'b1; c_up = 1'b1; end
      8'h2D: is_pm = 1'b1;
      8'h3E: begin is_lr = 1'b1; c_up = 1'b1; end
      8'h3C: is_lr = 1'b1;
      8'h2E: begin is_cmd = 1'b1; c_kind = K_DOT;   end
      8'h2C: begin is_cmd = 1'b1; c_kind = K_COMMA; end
      8'h5B: begin is_cmd = 1'b1; c_kind = K_OPEN;  end
      8'h5D: begin is_cmd = 1'b1; c_kind = K_CLOSE; end
      default: ;
    endcase
  end

  assign is_run    = is_pm | is_lr;
  assign step      = c_up ? 6'h01 : 6'h3F;
  assign run_sum   = run_d + step;
  assign pend      = |run_d;
  assign sat       = pend && (run_cls == is_pm) &&
                     (c_up ? (run_d == 6'h1F) : (run_d == 6'h20));
  assign run_byte  = {1'b0, run_cls, run_d};

  assign xfer      = in_valid && in_ready;
  assign addr_full = &prog_len;
  assign stk_empty = (depth == '0);
  assign stk_full  = (depth == DEPTH_FULL);
  assign top_idx   = SDEPTH'(depth - 1'b1);
  assign top       = stk[top_idx];
  assign off13     = 13'(off_q);
  assign bad_cmd   = is_cmd && ((c_kind == K_CLOSE && stk_empty) ||
                                (c_kind == K_OPEN  && stk_full));
  // Stack depth after this character would be non-zero at end of program
  assign last_unbal = (is_cmd && c_kind == K_OPEN) ? 1'b1 :
                      (is_cmd && c_kind == K_CLOSE) ? (depth != DEPTH_FULL'(1)) :
                      !stk_empty;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= ACCEPT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = prog_len;
    wr_byte   = 8'h00;
    len_inc   = 1'b0;
    run_cls_n = run_cls;
    run_d_n   = run_d;
    hold_ld   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      ACCEPT: begin
        if (xfer) begin
          hold_ld = 1'b1;
          if (bad_cmd || (in_last && last_unbal)) begin
            state_nxt = ERROR;
          end else if (is_run) begin
            if (pend && (run_cls != is_pm || sat)) begin
              // split: old run written now, new run seeded at +/-1
              if (addr_full) state_nxt = ERROR;
              else begin
                wr_en     = 1'b1;
                wr_byte   = run_byte;
                len_inc   = 1'b1;
                run_cls_n = is_pm;
                run_d_n   = step;
                if (sat || in_last) state_nxt = FLUSH;
              end
            end else begin
              run_cls_n = is_pm;
              run_d_n   = run_sum;
              if (in_last) begin
                run_d_n = '0;
                if (run_sum == '0) state_nxt = DONE;
                else if (addr_full) state_nxt = ERROR;
                else begin
                  wr_en     = 1'b1;
                  wr_byte   = {1'b0, is_pm, run_sum};
                  len_inc   = 1'b1;
                  state_nxt = DONE;
                end
              end
            end
          end else if (is_cmd) begin
            if (addr_full) state_nxt = ERROR;
            else if (pend) begin
              wr_en     = 1'b1;
              wr_byte   = run_byte;
              len_inc   = 1'b1;
              run_d_n   = '0;
              state_nxt = EMIT;
            end else begin
              wr_en     = 1'b1;
              wr_byte   = cmd_byte(c_kind);
              len_inc   = 1'b1;
              pop       = (c_kind == K_CLOSE);
              state_nxt = after_cmd(c_kind, in_last);
            end
          end else if (in_last) begin
            if (!pend) state_nxt = DONE;
            else if (addr_full) state_nxt = ERROR;
            else begin
              wr_en     = 1'b1;
              wr_byte   = run_byte;
              len_inc   = 1'b1;
              run_d_n   = '0;
              state_nxt = DONE;
            end
          end
        end
      end
      FLUSH: begin
        if (!last_q) state_nxt = ACCEPT;
        else if (addr_full) state_nxt = ERROR;
        else begin
          wr_en     = 1'b1;
          wr_byte   = run_byte;
          len_inc   = 1'b1;
          run_d_n   = '0;
          state_nxt = DONE;
        end
      end
      EMIT: begin
        if (addr_full) state_nxt = ERROR;
        else begin
          wr_en     = 1'b1;
          wr_byte   = cmd_byte(cmd_q);
          len_inc   = 1'b1;
          pop       = (cmd_q == K_CLOSE);
          state_nxt = after_cmd(cmd_q, last_q);
        end
      end
      BR_LO: begin
        if (addr_full) state_nxt = ERROR;
        else begin
          wr_en     = 1'b1;
          wr_byte   = 8'h00;
          len_inc   = 1'b1;
          push      = 1'b1;
          state_nxt = ACCEPT;
        end
      end
      CL_PATCH_HI: begin
        wr_en     = 1'b1;
        wr_addr   = s_q - CADDR_WIDTH'(1);
        wr_byte   = {3'b101, off13[12:8]};
        state_nxt = CL_PATCH_LO;
      end
      CL_PATCH_LO: begin
        wr_en     = 1'b1;
        wr_addr   = s_q;
        wr_byte   = off13[7:0];
        state_nxt = last_q ? DONE : ACCEPT;
      end
      DONE:  state_nxt = DONE;
      ERROR: state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_comb begin
    in_ready = resetq && (state == ACCEPT);
    done     = (state == DONE);
    error    = (state == ERROR);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      code_wr    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= '0;
      prog_len   <= '0;
      run_cls    <= 1'b0;
      run_d      <= '0;
      cmd_q      <= K_DOT;
      last_q     <= 1'b0;
      depth      <= '0;
      s_q        <= '0;
      off_q      <= '0;
    end else begin
      code_wr <= wr_en;
      if (wr_en) begin
        code_waddr <= wr_addr;
        code_wdata <= wr_byte;
      end
      if (len_inc) prog_len <= prog_len + CADDR_WIDTH'(1);
      run_cls <= run_cls_n;
      run_d   <= run_d_n;
      if (hold_ld) begin
        cmd_q  <= c_kind;
        last_q <= in_last;
      end
      if (push) depth <= depth + 1'b1;
      if (pop) begin
        // ']' lands at prog_len; jump target is the address after it
        depth <= depth - 1'b1;
        s_q   <= top;
        off_q <= prog_len + CADDR_WIDTH'(1) - top;
      end
    end
  end

  // Stack storage needs no reset: depth alone defines what is valid
  always_ff @(posedge clk) begin
    if (push) stk[SDEPTH'(depth)] <= prog_len;
  end

endmodule

// File: doc/bf_loader.md
BF_LOADER -- requirements
Module: bf_loader

Interface
REQ-001 Parameter CADDR_WIDTH, default 13: code address width, matching the core's code_addr.
REQ-002 Parameter SDEPTH, default 5: bracket stack holds 2**SDEPTH entries.
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 resetq  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data/in_last valid.
REQ-006 in_ready  output  1  loader accepts this cycle; a transfer is in_valid && in_ready at posedge.
REQ-007 in_data  input  8  ASCII source character.
REQ-008 in_last  input  1  marks the final character of the program.
REQ-009 code_wr  output  1  code memory write strobe, one write per cycle.
REQ-010 code_waddr  output  CADDR_WIDTH  code memory write address.
REQ-011 code_wdata  output  8  encoded instruction byte.
REQ-012 done  output  1  sticky; program fully emitted.
REQ-013 error  output  1  sticky; program rejected.
REQ-014 prog_len  output  CADDR_WIDTH  bytes emitted so far (next free address).

Function
REQ-015 Encoding: '<'/'>' = {2'b00, d[5:0]}; '+'/'-' = {2'b01, d[5:0]}; d is a signed net delta in -32..31 ('>' and '+' count +1; '<' and '-' count -1).
REQ-016 Encoding: ']' = 8'h80; ',' = 8'hC0; '.' = 8'hE0.
REQ-017 Encoding: '[' = two bytes, {3'b101, off[12:8]} at S-1 and off[7:0] at S, where S is the address of the second byte.
REQ-018 For '[', off = (address after the matching ']') - S.
REQ-019 Characters other than the eight commands are consumed and ignored (no write, no stall).
REQ-020 Run merge: consecutive characters of the same class ({+,-} or {<,>}) accumulate into one pending delta.
REQ-021 The pending run is flushed (one byte written) before any byte of a different command is written, and on in_last.
REQ-022 A pending run with net delta 0 is discarded without a write.
REQ-023 Saturation: if a character would take the delta outside -32..31, the current run is flushed and a new run starts at ±1.
REQ-024 FSM states: ACCEPT, FLUSH, EMIT, BR_LO, CL_PATCH_HI, CL_PATCH_LO, DONE, ERROR.
REQ-025 in_ready is 1 only in ACCEPT.
REQ-026 Outputs are registered: code_wr pulses the cycle after the transfer that causes the write.
REQ-027 Each extra byte beyond the first costs one cycle with in_ready=0.
REQ-028 '[' handling: write 8'hA0 at P; write 8'h00 at P+1 (state BR_LO); push P+1.
REQ-029 ']' handling: write 8'h80 at A; pop S; write {3'b101, off[12:8]} at S-1 (CL_PATCH_HI); write off[7:0] at S (CL_PATCH_LO), with off = A+1-S.
REQ-030 prog_len increments by 1 per emitted (non-patch) byte; patch writes leave it unchanged.
REQ-031 Error conditions: ']' with empty stack; '[' with full stack; any emit at address 2**CADDR_WIDTH-1 or above; in_last with non-empty stack.
REQ-032 On an error condition → ERROR: error=1, in_ready=0, no further writes until reset.
REQ-033 in_last accepted without error → flush if needed → DONE: done=1, in_ready=0.
REQ-034 prog_len is frozen in DONE and ERROR.

Reset
REQ-035 resetq low asynchronously forces ACCEPT with an empty stack, empty run, and prog_len=0.
REQ-036 Under reset: in_ready=0 while resetq is low; code_wr=0, code_waddr=0, code_wdata=0, done=0, error=0.
REQ-037 Reset mid-patch abandons the sequence; the memory contents already written are undefined to the core.

Verification
REQ-038 "+++" with in_last on the final '+' → single write addr0=8'h43; done=1; prog_len=1.
REQ-039 "<<x>" with in_last on '>' → single write addr0=8'h3F; 'x' ignored; prog_len=1.
REQ-040 "[-]" with in_last on ']' → writes, in order:
  - addr0=A0, addr1=00, addr2=7F, addr3=80
  - then addr0=A0, addr1=03
  - result: prog_len=4, done=1.
REQ-041 34 consecutive '+' → addr0=8'h5F (delta 31), addr1=8'h43 (delta 3); in_ready low exactly 1 cycle at the split.
REQ-042 "]" or "[[" with in_last → error=1, done=0; no write after the error is detected; in_ready stays 0.
REQ-043 Reset asserted during CL_PATCH_HI → error=0, done=0, prog_len=0, in_ready=1 the first cycle after release.
